// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-wire timing engine: command encodings, FSM
// states and standard-speed slot timing (all durations in microseconds).
package onewire_pkg;

    localparam int US_COUNT_WIDTH = 10;
    typedef logic [US_COUNT_WIDTH-1:0] usCountType;

    // Host command encodings; 5..7 are reserved and complete without bus activity.
    typedef enum logic [2:0] {
        CMD_RESET      = 3'd0,
        CMD_WRITE_BIT  = 3'd1,
        CMD_READ_BIT   = 3'd2,
        CMD_WRITE_BYTE = 3'd3,
        CMD_READ_BYTE  = 3'd4
    } cmdType;

    typedef enum logic [1:0] {IDLE, LOW, RELEASE, DONE} stateType;

    localparam int RESET_LOW_US       = 480;
    localparam int RESET_RELEASE_US   = 480;
    localparam int RESET_SAMPLE_US    = 70;
    localparam int WRITE1_LOW_US      = 6;
    localparam int WRITE1_RELEASE_US  = 64;
    localparam int WRITE0_LOW_US      = 60;
    localparam int WRITE0_RELEASE_US  = 10;
    localparam int READ_LOW_US        = 6;
    localparam int READ_RELEASE_US    = 64;
    localparam int READ_SAMPLE_US     = 9;

    // Durations are stored as the index of their last microsecond so the
    // FSM compares directly against the timer's zero-based count.
    typedef struct packed {
        usCountType lowLast;
        usCountType releaseLast;
        usCountType sampleLast;
        logic       sampleEnable;
    } slotType;

    function automatic usCountType lastUs(input int us);
        return usCountType'(us - 1);
    endfunction

    function automatic logic isReadCmd(input logic [2:0] c);
        return (c == CMD_READ_BIT) || (c == CMD_READ_BYTE);
    endfunction

    function automatic logic isByteCmd(input logic [2:0] c);
        return (c == CMD_WRITE_BYTE) || (c == CMD_READ_BYTE);
    endfunction

    function automatic logic isReservedCmd(input logic [2:0] c);
        return c > CMD_READ_BYTE;
    endfunction

    function automatic slotType slotFor(input logic [2:0] c, input logic bitValue);
        slotType slot;
        slot.sampleEnable = 1'b0;
        slot.sampleLast   = '0;
        case (c)
            CMD_RESET: begin
                slot.lowLast      = lastUs(RESET_LOW_US);
                slot.releaseLast  = lastUs(RESET_RELEASE_US);
                slot.sampleLast   = lastUs(RESET_SAMPLE_US);
                slot.sampleEnable = 1'b1;
            end
            CMD_READ_BIT, CMD_READ_BYTE: begin
                slot.lowLast      = lastUs(READ_LOW_US);
                slot.releaseLast  = lastUs(READ_RELEASE_US);
                slot.sampleLast   = lastUs(READ_SAMPLE_US);
                slot.sampleEnable = 1'b1;
            end
            default: begin
                slot.lowLast     = bitValue ? lastUs(WRITE1_LOW_US)     : lastUs(WRITE0_LOW_US);
                slot.releaseLast = bitValue ? lastUs(WRITE1_RELEASE_US) : lastUs(WRITE0_RELEASE_US);
            end
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/onewire_us_timer.sv
// Microsecond time base: a prescaler dividing clock29M by TICKS_PER_US and a
// microsecond counter, both synchronously cleared.
//   clock29M, reset : clock and synchronous active-high reset
//   clear           : zero prescaler and counter on the next edge
//   usTick          : high on the last clock cycle of each microsecond
//   usCount         : whole microseconds elapsed since the last clear
module onewire_us_timer
    import onewire_pkg::*;
#(
    parameter int TICKS_PER_US = 29
) (
    input  logic       clock29M,
    input  logic       reset,
    input  logic       clear,
    output logic       usTick,
    output usCountType usCount
);

    localparam int PRESCALE_WIDTH = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_LAST = PRESCALE_WIDTH'(TICKS_PER_US - 1);

    logic [PRESCALE_WIDTH-1:0] prescale;

    assign usTick = (prescale == PRESCALE_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock29M) begin
        if (reset || clear) begin
            prescale <= '0;
            usCount  <= '0;
        end else if (usTick) begin
            prescale <= '0;
            usCount  <= usCount + 1'b1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

endmodule

// File: rtl/onewire_master.sv
// 1-wire standard-speed timing engine between the host register logic and
// the open-drain DS2401/DS2433 pad buffers.
//   cmdValid/cmdReady/cmd/cmdData/busSelect : host command handshake
//   done      : one-cycle completion pulse
//   presence  : device answered the last RESET
//   readData  : last read result (READ_BIT in bit 7, READ_BYTE LSB-first)
//   ds2401Sense/ds2433Sense : registered bus levels from the IOBs
//   ds2401Drive/ds2433Drive : 1 pulls the corresponding bus low
module onewire_master
    import onewire_pkg::*;
#(
    parameter int TICKS_PER_US = 29
) (
    input  logic       clock29M,
    input  logic       reset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [2:0] cmd,
    input  logic [7:0] cmdData,
    input  logic       busSelect,
    output logic       done,
    output logic       presence,
    output logic [7:0] readData,
    input  logic       ds2401Sense,
    input  logic       ds2433Sense,
    output logic       ds2401Drive,
    output logic       ds2433Drive
);

    stateType   state, stateNext;
    logic [2:0] cmdReg;
    logic       busSel;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic       presSample;
    logic       usTick;
    usCountType usCount;
    slotType    slot;

    logic accept, timerClear, sense, lowEnd, releaseEnd, sampleNow, busNext;

    assign cmdReady   = (state == IDLE);
    assign done       = (state == DONE);
    assign accept     = cmdValid && cmdReady;
    assign sense      = busSel ? ds2433Sense : ds2401Sense;
    assign slot       = slotFor(cmdReg, shiftReg[0]);
    assign lowEnd     = usTick && (usCount == slot.lowLast);
    assign releaseEnd = usTick && (usCount == slot.releaseLast);
    assign sampleNow  = (state == RELEASE) && slot.sampleEnable && usTick &&
                        (usCount == slot.sampleLast);
    assign busNext    = accept ? busSelect : busSel;
    // Every state entry (including RELEASE -> LOW between byte slots)
    // restarts the microsecond time base.
    assign timerClear = (stateNext != state);

    onewire_us_timer #(.TICKS_PER_US(TICKS_PER_US)) usTimer (
        .clock29M (clock29M),
        .reset    (reset),
        .clear    (timerClear),
        .usTick   (usTick),
        .usCount  (usCount)
    );

    // NOTE: defaulting stateNext first keeps this block free of latches.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = isReservedCmd(cmd) ? DONE : LOW;
            LOW:     if (lowEnd) stateNext = RELEASE;
            RELEASE: if (releaseEnd) stateNext = (bitCnt == 3'd0) ? DONE : LOW;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock29M) begin
        if (reset) begin
            state       <= IDLE;
            cmdReg      <= '0;
            busSel      <= 1'b0;
            bitCnt      <= '0;
            shiftReg    <= '0;
            presSample  <= 1'b0;
            presence    <= 1'b0;
            readData    <= '0;
            ds2401Drive <= 1'b0;
            ds2433Drive <= 1'b0;
        end else begin
            state <= stateNext;
            // Drives are registered from the next state so the pads see a
            // clean flop output aligned with the LOW state.
            ds2401Drive <= (stateNext == LOW) && !busNext;
            ds2433Drive <= (stateNext == LOW) && busNext;

            if (accept) begin
                cmdReg     <= cmd;
                busSel     <= busSelect;
                bitCnt     <= isByteCmd(cmd) ? 3'd7 : 3'd0;
                // Reads start from zero so READ_BIT leaves only bit 7 set.
                shiftReg   <= isReadCmd(cmd) ? 8'h00 : cmdData;
                presSample <= 1'b0;
            end

            if (sampleNow) begin
                if (cmdReg == CMD_RESET) presSample <= ~sense;
                else                     shiftReg   <= {sense, shiftReg[7:1]};
            end

            if ((state == RELEASE) && releaseEnd) begin
                if (!isReadCmd(cmdReg)) shiftReg <= shiftReg >> 1;
                if (bitCnt != 3'd0)     bitCnt   <= bitCnt - 3'd1;
            end

            if (state == DONE) begin
                if (cmdReg == CMD_RESET) presence <= presSample;
                if (isReadCmd(cmdReg))   readData <= shiftReg;
            end
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// Self-checking bench for onewire_master with a simple 1-wire device model
// per bus and a pulse scoreboard.
module tb_onewire_master;
    import onewire_pkg::*;

    localparam int T = 4;

    logic       clock29M = 1'b0;
    logic       reset, cmdValid, busSelect;
    logic [2:0] cmd;
    logic [7:0] cmdData;
    logic       cmdReady, done, presence;
    logic [7:0] readData;
    logic       ds2401Sense = 1'b1, ds2433Sense = 1'b1;
    logic       ds2401Drive, ds2433Drive;

    always #5 clock29M = ~clock29M;

    onewire_master #(.TICKS_PER_US(T)) dut (
        .clock29M    (clock29M),
        .reset       (reset),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmd         (cmd),
        .cmdData     (cmdData),
        .busSelect   (busSelect),
        .done        (done),
        .presence    (presence),
        .readData    (readData),
        .ds2401Sense (ds2401Sense),
        .ds2433Sense (ds2433Sense),
        .ds2401Drive (ds2401Drive),
        .ds2433Drive (ds2433Drive)
    );

    typedef struct {int bus; int width; int gap;} pulseExpT;
    typedef struct {int bus; int width; int start;} pulseObsT;

    pulseExpT expQ[$];
    pulseObsT obsQ[$];

    int   testsRun = 0, testsFailed = 0;
    int   cyc = 0, doneCount = 0;
    int   driveCycles [2] = '{0, 0};
    int   lowCnt [2] = '{0, 0};
    int   relCnt [2] = '{0, 0};
    int   lastLow [2] = '{0, 0};
    int   lowStart [2] = '{0, 0};
    logic prevDrive [2] = '{1'b0, 1'b0};
    logic readSlot [2] = '{1'b0, 1'b0};
    logic curBit [2] = '{1'b1, 1'b1};
    logic present [2] = '{1'b0, 1'b0};
    logic [7:0] readBits [2] = '{8'hFF, 8'hFF};
    logic [7:0] expRead = 8'h00;

    // Device model and pulse monitor: records every low pulse, answers
    // presence 30..150 us after a reset pulse, and holds the bus low for
    // 30 us after a short slot when the next read bit is 0.
    always @(posedge clock29M) begin
        logic [1:0] drv;
        logic [1:0] senseNext;
        logic       pull;
        cyc++;
        drv = {ds2433Drive, ds2401Drive};
        if (done === 1'b1) doneCount++;
        for (int b = 0; b < 2; b++) begin
            if (drv[b]) begin
                if (!prevDrive[b]) lowStart[b] = cyc;
                lowCnt[b]++;
                relCnt[b] = 0;
                driveCycles[b]++;
            end else begin
                if (prevDrive[b]) begin
                    obsQ.push_back('{b, lowCnt[b], lowStart[b]});
                    lastLow[b]  = lowCnt[b];
                    readSlot[b] = lowCnt[b] < 15 * T;
                    if (readSlot[b]) begin
                        curBit[b]   = readBits[b][0];
                        readBits[b] = {readBits[b][0], readBits[b][7:1]};
                    end
                    lowCnt[b] = 0;
                end
                relCnt[b]++;
            end
            pull = 1'b0;
            if (!drv[b] && present[b] && lastLow[b] >= 480 * T &&
                relCnt[b] >= 30 * T && relCnt[b] < 150 * T) pull = 1'b1;
            if (!drv[b] && readSlot[b] && !curBit[b] && relCnt[b] < 30 * T) pull = 1'b1;
            senseNext[b] = !(drv[b] || pull);
            prevDrive[b] = drv[b];
        end
        ds2401Sense <= senseNext[0];
        ds2433Sense <= senseNext[1];
    end

    task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic b,
                         output int acceptCyc);
        int n = 0;
        @(negedge clock29M);
        while (cmdReady !== 1'b1 && n < 5000) begin
            @(negedge clock29M);
            n++;
        end
        testsRun++;
        if (cmdReady !== 1'b1) begin
            testsFailed++;
            $display("FAIL issue_ready: cmdReady=%b, wanted 1", cmdReady);
        end
        cmd = c; cmdData = d; busSelect = b; cmdValid = 1'b1;
        acceptCyc = cyc;
        @(negedge clock29M);
        cmdValid = 1'b0; cmd = 3'd7; cmdData = 8'h00; busSelect = ~b;
    endtask

    task automatic wait_done(input int budget, output int doneCyc);
        int n = 0;
        doneCyc = -1;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock29M);
            n++;
        end
        testsRun++;
        if (done !== 1'b1) begin
            testsFailed++;
            $display("FAIL done_timeout: done=%b after %0d cycles, wanted 1", done, budget);
        end else begin
            doneCyc = cyc;
        end
    endtask

    task automatic drain_scoreboard(input string name);
        int       prevStart = -1;
        pulseExpT e;
        pulseObsT o;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            testsRun++;
            if (obsQ.size() == 0) begin
                testsFailed++;
                $display("FAIL %s_pulse: no pulse observed, wanted bus %0d width %0d", name, e.bus, e.width);
            end else begin
                o = obsQ.pop_front();
                if (o.bus !== e.bus || o.width !== e.width ||
                    (e.gap >= 0 && (o.start - prevStart) !== e.gap)) begin
                    testsFailed++;
                    $display("FAIL %s_pulse: bus %0d width %0d gap %0d, wanted bus %0d width %0d gap %0d",
                             name, o.bus, o.width, o.start - prevStart, e.bus, e.width, e.gap);
                end
                prevStart = o.start;
            end
        end
        testsRun++;
        if (obsQ.size() !== 0) begin
            testsFailed++;
            $display("FAIL %s_extra: %0d extra pulses, wanted 0", name, obsQ.size());
        end
        obsQ.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; cmdValid = 1'b0; cmd = 3'd0; cmdData = 8'h00; busSelect = 1'b0;
        repeat (3) @(negedge clock29M);
        reset = 1'b0;
        @(negedge clock29M);
        testsRun++;
        if ({cmdReady, done, presence, readData, ds2401Drive, ds2433Drive} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            testsFailed++;
            $display("FAIL reset_values: ready=%b done=%b pres=%b rd=%h drv=%b%b, wanted 1 0 0 00 00",
                     cmdReady, done, presence, readData, ds2401Drive, ds2433Drive);
        end
        obsQ.delete();
    endtask

    task automatic test_bus_reset(input logic b, input logic dev);
        int acc, dc;
        present[b] = dev;
        driveCycles = '{0, 0};
        doneCount = 0;
        expQ.push_back('{int'(b), 480 * T, -1});
        issue(CMD_RESET, 8'h00, b, acc);
        testsRun++;
        if ((b ? ds2433Drive : ds2401Drive) !== 1'b1) begin
            testsFailed++;
            $display("FAIL rst_drive_start: drive=%b, wanted 1", b ? ds2433Drive : ds2401Drive);
        end
        wait_done(1100 * T, dc);
        testsRun++;
        if (dc - acc !== 960 * T + 1) begin
            testsFailed++;
            $display("FAIL rst_latency: %0d cycles, wanted %0d", dc - acc, 960 * T + 1);
        end
        testsRun++;
        if (cmdReady !== 1'b0) begin
            testsFailed++;
            $display("FAIL rst_ready_in_done: cmdReady=%b, wanted 0", cmdReady);
        end
        @(negedge clock29M);
        testsRun++;
        if ({presence, cmdReady, done} !== {dev, 1'b1, 1'b0}) begin
            testsFailed++;
            $display("FAIL rst_presence: pres=%b ready=%b done=%b, wanted %b 1 0", presence, cmdReady, done, dev);
        end
        testsRun++;
        if (driveCycles[~b] !== 0 || doneCount !== 1) begin
            testsFailed++;
            $display("FAIL rst_other_bus: other drive cycles %0d done pulses %0d, wanted 0 and 1",
                     driveCycles[~b], doneCount);
        end
        drain_scoreboard("rst");
    endtask

    task automatic test_reset_mid();
        int acc;
        present[0] = 1'b1;
        issue(CMD_RESET, 8'h00, 1'b0, acc);
        repeat (100) @(negedge clock29M);
        reset = 1'b1;
        @(negedge clock29M);
        reset = 1'b0;
        testsRun++;
        if ({ds2401Drive, ds2433Drive, cmdReady, done, presence, readData} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            testsFailed++;
            $display("FAIL mid_reset: drv=%b%b ready=%b done=%b pres=%b rd=%h, wanted 00 1 0 0 00",
                     ds2401Drive, ds2433Drive, cmdReady, done, presence, readData);
        end
        doneCount = 0;
        repeat (1000 * T) @(negedge clock29M);
        testsRun++;
        if (doneCount !== 0 || ds2401Drive !== 1'b0) begin
            testsFailed++;
            $display("FAIL mid_no_done: done pulses %0d drive %b, wanted 0 and 0", doneCount, ds2401Drive);
        end
        expRead = 8'h00;
        obsQ.delete();
    endtask

    task automatic test_transfer(input string name, input logic [2:0] c, input logic [7:0] d,
                                 input logic b, input logic [7:0] bits);
        int acc, dc, slots;
        logic rd;
        rd = isReadCmd(c);
        slots = isByteCmd(c) ? 8 : 1;
        readBits[b] = bits;
        driveCycles = '{0, 0};
        for (int i = 0; i < slots; i++)
            expQ.push_back('{int'(b), (rd || d[i]) ? 6 * T : 60 * T, (i == 0) ? -1 : 70 * T});
        if (rd) expRead = (slots == 8) ? bits : {bits[0], 7'b0};
        issue(c, d, b, acc);
        wait_done(600 * T, dc);
        testsRun++;
        if (dc - acc !== slots * 70 * T + 1) begin
            testsFailed++;
            $display("FAIL %s_latency: %0d cycles, wanted %0d", name, dc - acc, slots * 70 * T + 1);
        end
        @(negedge clock29M);
        testsRun++;
        if (readData !== expRead || driveCycles[~b] !== 0) begin
            testsFailed++;
            $display("FAIL %s_data: readData=%h other drive cycles %0d, wanted %h and 0",
                     name, readData, driveCycles[~b], expRead);
        end
        drain_scoreboard(name);
    endtask

    task automatic test_busy_ignore();
        int acc, acc2, dc, n;
        readBits[0] = 8'hFF;
        doneCount = 0;
        expRead = 8'h80;
        expQ.push_back('{0, 6 * T, -1});
        expQ.push_back('{0, 60 * T, -1});
        issue(CMD_READ_BIT, 8'h00, 1'b0, acc);
        cmd = CMD_WRITE_BIT; cmdData = 8'h00; busSelect = 1'b0; cmdValid = 1'b1;
        n = 0;
        while (cmdReady !== 1'b1 && n < 200 * T) begin
            @(negedge clock29M);
            n++;
        end
        acc2 = cyc;
        testsRun++;
        if (doneCount !== 1 || readData !== 8'h80) begin
            testsFailed++;
            $display("FAIL busy_first: done pulses %0d readData %h, wanted 1 and 80", doneCount, readData);
        end
        @(negedge clock29M);
        cmdValid = 1'b0;
        testsRun++;
        if (ds2401Drive !== 1'b1) begin
            testsFailed++;
            $display("FAIL busy_b2b_accept: drive=%b, wanted 1", ds2401Drive);
        end
        wait_done(100 * T, dc);
        testsRun++;
        if (dc - acc2 !== 70 * T + 1) begin
            testsFailed++;
            $display("FAIL busy_latency: %0d cycles, wanted %0d", dc - acc2, 70 * T + 1);
        end
        @(negedge clock29M);
        testsRun++;
        if (doneCount !== 2 || readData !== 8'h80 || cmdReady !== 1'b1) begin
            testsFailed++;
            $display("FAIL busy_second: done pulses %0d readData %h ready %b, wanted 2 80 1",
                     doneCount, readData, cmdReady);
        end
        drain_scoreboard("busy");
    endtask

    task automatic test_reserved();
        int acc;
        logic presBefore;
        presBefore = presence;
        driveCycles = '{0, 0};
        issue(3'd5, 8'h00, 1'b1, acc);
        testsRun++;
        if (done !== 1'b1 || readData !== expRead || presence !== presBefore) begin
            testsFailed++;
            $display("FAIL reserved_done: done=%b readData=%h pres=%b, wanted 1 %h %b",
                     done, readData, presence, expRead, presBefore);
        end
        @(negedge clock29M);
        testsRun++;
        if (driveCycles[0] + driveCycles[1] !== 0 || cmdReady !== 1'b1) begin
            testsFailed++;
            $display("FAIL reserved_bus: drive cycles %0d ready %b, wanted 0 and 1",
                     driveCycles[0] + driveCycles[1], cmdReady);
        end
        drain_scoreboard("reserved");
    endtask

    initial begin
        test_reset();
        test_bus_reset(1'b0, 1'b1);
        test_reset_mid();
        test_bus_reset(1'b1, 1'b0);
        test_transfer("rdbyte", CMD_READ_BYTE, 8'h00, 1'b1, 8'h3C);
        test_transfer("wrbyte", CMD_WRITE_BYTE, 8'hA5, 1'b0, 8'hFF);
        test_transfer("wrbit1", CMD_WRITE_BIT, 8'h01, 1'b1, 8'hFF);
        test_transfer("wrbit0", CMD_WRITE_BIT, 8'hFE, 1'b1, 8'hFF);
        test_transfer("rdbit0", CMD_READ_BIT, 8'hFF, 1'b1, 8'hFE);
        test_busy_ignore();
        test_reserved();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
